sdr_audio_dac: RTL and testbench
================================

Name: sdr_audio_dac

Overview:
Parametrised multi-channel audio output stage for the SDR receive chain. It sits after the demodulator/resampler and takes signed baseband audio on a clock-enable strobe. Each channel gets programmable gain, arithmetic shift, saturation with a clip counter, and an offset-binary conversion. Each channel then drives a 1-bit output through either bit-reversed PWM or a first-order sigma-delta modulator, and all settings are reachable over a Wishbone register file.

Parameters:
NCHAN, 2, number of independent audio channels
IW, 16, input sample width (signed, per channel)
GW, 16, gain register width (signed)
PWM_BITS, 16, output level width (offset binary)
CLIP_BITS, 16, clip counter width (saturating)

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous active-high reset
i_en  in  1  output enable; 0 forces idle toggle pattern
i_wb_cyc  in  1  Wishbone cycle (unused)
i_wb_stb  in  1  Wishbone strobe
i_wb_we  in  1  Wishbone write enable
i_wb_addr  in  2  register address
i_wb_data  in  32  write data
i_wb_sel  in  4  byte select (ignored; writes are full-word)
o_wb_stall  out  1  always 0
o_wb_ack  out  1  bus acknowledge
o_wb_data  out  32  read data
i_ce  in  1  sample strobe, any rate up to every clock
i_sample  in  NCHAN*IW  channel c occupies bits [c*IW +: IW], signed
o_pwm  out  NCHAN  1-bit audio per channel
o_clip  out  1  one-clock pulse when any channel saturates

Behaviour:
- Clocking and reset are fixed: one clock, i_clk; reset is i_reset, synchronous and active-high.
- Reset values:
  - gain=0, mode=0, mute=0, shift=0, clip_count=0.
  - Pipeline valid bits cleared; every level register = 1<<(PWM_BITS-1) (midscale).
  - PWM counter and sigma-delta accumulators = 0.
  - o_pwm=0, o_clip=0, o_wb_ack=0, o_wb_data=0.
- Register map:
  - Addr 0, gain: signed, data[GW-1:0]; reads back sign-extended.
  - Addr 1, control: bit0 mode (0=PWM, 1=sigma-delta), bit1 mute, bits[12:8] shift (0..31); other bits read 0.
  - Addr 2, clip_count: read-only count; any write clears it.
  - Addr 3, last level of channel 0: read-only, zero-extended.
- Bus timing:
  - o_wb_ack = !i_reset && i_wb_stb, registered, one clock after the strobe.
  - o_wb_data is registered with the addressed register's value (pre-write) on every strobe.
  - Writes take effect on the clock after the strobe.
- Pipeline (fully pipelined, accepts i_ce every clock; one i_ce with samples at cycle n):
  - n+1: per-channel signed product = sample * gain, width IW+GW. Gain sampled at cycle n.
  - n+2: product >>> shift (arithmetic), then saturate to signed PWM_BITS. Per-channel clip flag set if saturation occurred. Shift sampled at n+1.
  - n+3: level[c] = saturated value with MSB inverted (offset binary). If mute is set, level = midscale.
  - n+3: o_clip pulses if any channel clipped.
  - n+3: clip_count += 1 (at most 1 per sample), holding at all-ones. A clear write in the same clock wins over the increment.
- Output, PWM mode:
  - One shared free-running PWM_BITS counter, bit-reversed.
  - o_pwm[c] <= (brev_counter < level[c]), registered.
- Output, sigma-delta mode:
  - Per-channel accumulator {carry, acc} <= acc + level[c], PWM_BITS+1 bits.
  - o_pwm[c] <= carry.
  - Switching mode does not reset the accumulators.
- i_en=0: every o_pwm bit toggles each clock (keeps the output DC-balanced). The datapath and counters continue running.
- Reset mid-operation: in-flight samples are discarded, levels return to midscale, and no clip is counted for discarded samples.

Test Plan:
1. Reset, then read addrs 0..3 -> ack one clock after each strobe; data 0, 0, 0, 0x8000. o_pwm low during reset.
2. gain=0x0100, shift=8, i_ce with ch0=0x1000, ch1=0xF000 -> exactly 3 clocks later level0=0x9000 and level1=0x7000. No clip; addr 3 reads 0x9000.
3. Sigma-delta mode with level0=0x9000 held -> exactly 36864 ones on o_pwm[0] over 65536 clocks. PWM mode with the same level -> also 36864 ones per 65536-clock period.
4. gain=0x7FFF, shift=0, ch0=0x7FFF then ch0=0x8000 on consecutive clocks -> levels 0xFFFF then 0x0000, two o_clip pulses, clip_count=2. A clip coincident with a write to addr 2 -> count reads 0.
5. mute=1 with nonzero samples -> level stays 0x8000. i_en=0 -> o_pwm alternates 1,0,1,0 every clock.
6. i_ce asserted on back-to-back clocks with a ramp input, with i_reset pulsed mid-stream -> outputs match a reference model with 3-clock latency. No level updates from pre-reset samples appear after reset.

Source files
------------

// File: rtl/sdr_audio_dac.sv
// sdr_audio_dac: multi-channel audio output stage. Each channel applies a signed gain,
// an arithmetic right shift and saturation, converts to offset binary and drives a 1-bit
// output through either bit-reversed PWM or a first-order sigma-delta modulator.
// Gain, mode, mute, shift and the clip counter live in a small Wishbone register file.
module sdr_audio_dac #(
    parameter int unsigned NCHAN     = 2,
    parameter int unsigned IW        = 16,
    parameter int unsigned GW        = 16,
    parameter int unsigned PWM_BITS  = 16,
    parameter int unsigned CLIP_BITS = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_en,
    input  logic                  i_wb_cyc,
    input  logic                  i_wb_stb,
    input  logic                  i_wb_we,
    input  logic [1:0]            i_wb_addr,
    input  logic [31:0]           i_wb_data,
    input  logic [3:0]            i_wb_sel,
    output logic                  o_wb_stall,
    output logic                  o_wb_ack,
    output logic [31:0]           o_wb_data,
    input  logic                  i_ce,
    input  logic [NCHAN*IW-1:0]   i_sample,
    output logic [NCHAN-1:0]      o_pwm,
    output logic                  o_clip
);

    // Full-precision product width.
    localparam int unsigned PW = IW + GW;

    localparam logic [PWM_BITS-1:0]  MIDSCALE = {1'b1, {(PWM_BITS-1){1'b0}}};
    localparam logic [PWM_BITS-1:0]  SAT_MAX  = {1'b0, {(PWM_BITS-1){1'b1}}};
    localparam logic [PWM_BITS-1:0]  SAT_MIN  = {1'b1, {(PWM_BITS-1){1'b0}}};
    localparam logic [PWM_BITS-1:0]  CNT_ONE  = {{(PWM_BITS-1){1'b0}}, 1'b1};
    localparam logic [CLIP_BITS-1:0] CLIP_MAX = {CLIP_BITS{1'b1}};
    localparam logic [CLIP_BITS-1:0] CLIP_ONE = {{(CLIP_BITS-1){1'b0}}, 1'b1};

    localparam logic [1:0] ADDR_GAIN  = 2'd0;
    localparam logic [1:0] ADDR_CTRL  = 2'd1;
    localparam logic [1:0] ADDR_CLIP  = 2'd2;
    localparam logic [1:0] ADDR_LEVEL = 2'd3;

    // ------------------------------------------------------------------
    // Register file state
    // ------------------------------------------------------------------
    logic signed [GW-1:0]  gain_q, gain_d;
    logic                  mode_q, mode_d;
    logic                  mute_q, mute_d;
    logic [4:0]            shift_q, shift_d;
    logic [CLIP_BITS-1:0]  clip_cnt_q, clip_cnt_d;
    logic                  ack_q;
    logic [31:0]           rdata_q, rdata_d;
    logic [31:0]           rd_mux;
    logic                  wr_en;
    logic                  clip_clr;

    // ------------------------------------------------------------------
    // Datapath state
    // ------------------------------------------------------------------
    logic                  v1_q;
    logic signed [PW-1:0]  prod_q [NCHAN];
    logic signed [PW-1:0]  prod_d [NCHAN];

    logic                  v2_q;
    logic signed [PW-1:0]  shifted [NCHAN];
    logic [PW-PWM_BITS:0]  hi_bits [NCHAN];
    logic [PWM_BITS-1:0]   sat_q [NCHAN];
    logic [PWM_BITS-1:0]   sat_d [NCHAN];
    logic [NCHAN-1:0]      clip2_q, clip2_d;

    logic [PWM_BITS-1:0]   level_q [NCHAN];
    logic [PWM_BITS-1:0]   level_d [NCHAN];
    logic                  clip_q, clip_d;

    // ------------------------------------------------------------------
    // Output modulator state
    // ------------------------------------------------------------------
    logic [PWM_BITS-1:0]   cnt_q, cnt_d;
    logic [PWM_BITS-1:0]   brev;
    logic [PWM_BITS-1:0]   acc_q [NCHAN];
    logic [PWM_BITS-1:0]   acc_d [NCHAN];
    logic [PWM_BITS:0]     acc_sum [NCHAN];
    logic [NCHAN-1:0]      pwm_q, pwm_d;

    // Bus signals with no function here; kept visible so nothing dangles.
    logic unused_bus;
    assign unused_bus = ^{i_wb_cyc, i_wb_sel, i_wb_data};

    assign o_wb_stall = 1'b0;
    assign o_wb_ack   = ack_q;
    assign o_wb_data  = rdata_q;
    assign o_pwm      = pwm_q;
    assign o_clip     = clip_q;

    // Read mux: always reflects the register contents before any same-cycle write.
    always_comb begin
        rd_mux = '0;
        case (i_wb_addr)
            ADDR_GAIN:  rd_mux = 32'(gain_q);
            ADDR_CTRL: begin
                rd_mux[0]    = mode_q;
                rd_mux[1]    = mute_q;
                rd_mux[12:8] = shift_q;
            end
            ADDR_CLIP:  rd_mux = 32'(clip_cnt_q);
            ADDR_LEVEL: rd_mux = 32'(level_q[0]);
            default:    rd_mux = '0;
        endcase
    end

    // Register-file next state; a clear write to the clip counter beats an increment.
    always_comb begin
        wr_en      = i_wb_stb && i_wb_we;
        gain_d     = gain_q;
        mode_d     = mode_q;
        mute_d     = mute_q;
        shift_d    = shift_q;
        clip_clr   = 1'b0;
        rdata_d    = i_wb_stb ? rd_mux : rdata_q;
        if (wr_en) begin
            case (i_wb_addr)
                ADDR_GAIN: gain_d = i_wb_data[GW-1:0];
                ADDR_CTRL: begin
                    mode_d  = i_wb_data[0];
                    mute_d  = i_wb_data[1];
                    shift_d = i_wb_data[12:8];
                end
                ADDR_CLIP: clip_clr = 1'b1;
                default: ;
            endcase
        end
        if (clip_clr) begin
            clip_cnt_d = '0;
        end else if (clip_d && (clip_cnt_q != CLIP_MAX)) begin
            clip_cnt_d = clip_cnt_q + CLIP_ONE;
        end else begin
            clip_cnt_d = clip_cnt_q;
        end
    end

    // Register file, bus acknowledge and read-data registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            gain_q     <= '0;
            mode_q     <= 1'b0;
            mute_q     <= 1'b0;
            shift_q    <= '0;
            clip_cnt_q <= '0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            gain_q     <= gain_d;
            mode_q     <= mode_d;
            mute_q     <= mute_d;
            shift_q    <= shift_d;
            clip_cnt_q <= clip_cnt_d;
            ack_q      <= i_wb_stb;
            rdata_q    <= rdata_d;
        end
    end

    // Stage 1: full-precision signed product of each sample with the current gain.
    always_comb begin
        for (int c = 0; c < NCHAN; c++) begin
            prod_d[c] = $signed({{GW{i_sample[c*IW+IW-1]}}, i_sample[c*IW +: IW]})
                      * $signed({{IW{gain_q[GW-1]}}, gain_q});
        end
    end

    // Stage 2: arithmetic shift, then saturate when the discarded high bits are not
    // all copies of the new sign bit.
    always_comb begin
        clip2_d = '0;
        for (int c = 0; c < NCHAN; c++) begin
            shifted[c] = prod_q[c] >>> shift_q;
            hi_bits[c] = shifted[c][PW-1:PWM_BITS-1];
            if ((&hi_bits[c]) || !(|hi_bits[c])) begin
                sat_d[c] = shifted[c][PWM_BITS-1:0];
            end else begin
                sat_d[c]   = shifted[c][PW-1] ? SAT_MIN : SAT_MAX;
                clip2_d[c] = 1'b1;
            end
        end
    end

    // Stage 3: offset-binary level (midscale when muted) and the any-channel clip pulse.
    always_comb begin
        clip_d = v2_q && (|clip2_q);
        for (int c = 0; c < NCHAN; c++) begin
            level_d[c] = mute_q ? MIDSCALE : {~sat_q[c][PWM_BITS-1], sat_q[c][PWM_BITS-2:0]};
        end
    end

    // Pipeline registers; data stages only load when their valid bit is set.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            clip2_q <= '0;
            clip_q  <= 1'b0;
            for (int c = 0; c < NCHAN; c++) begin
                level_q[c] <= MIDSCALE;
            end
        end else begin
            v1_q   <= i_ce;
            v2_q   <= v1_q;
            clip_q <= clip_d;
            if (v1_q) begin
                clip2_q <= clip2_d;
            end
            for (int c = 0; c < NCHAN; c++) begin
                if (i_ce) begin
                    prod_q[c] <= prod_d[c];
                end
                if (v1_q) begin
                    sat_q[c] <= sat_d[c];
                end
                if (v2_q) begin
                    level_q[c] <= level_d[c];
                end
            end
        end
    end

    // Modulators: shared bit-reversed PWM ramp and per-channel sigma-delta accumulators.
    // Both keep running regardless of mode or enable so switching is glitch-free.
    always_comb begin
        cnt_d = cnt_q + CNT_ONE;
        brev  = '0;
        for (int i = 0; i < PWM_BITS; i++) begin
            brev[i] = cnt_q[PWM_BITS-1-i];
        end
        pwm_d = '0;
        for (int c = 0; c < NCHAN; c++) begin
            acc_sum[c] = {1'b0, acc_q[c]} + {1'b0, level_q[c]};
            acc_d[c]   = acc_sum[c][PWM_BITS-1:0];
            if (!i_en) begin
                // Idle pattern: toggle every clock to stay DC-balanced.
                pwm_d[c] = ~pwm_q[c];
            end else if (mode_q) begin
                pwm_d[c] = acc_sum[c][PWM_BITS];
            end else begin
                pwm_d[c] = (brev < level_q[c]);
            end
        end
    end

    // Modulator registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
            pwm_q <= '0;
            for (int c = 0; c < NCHAN; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
            for (int c = 0; c < NCHAN; c++) begin
                acc_q[c] <= acc_d[c];
            end
        end
    end

endmodule

// File: tb/tb_sdr_audio_dac.sv
// Bench for sdr_audio_dac: directed scenarios and a randomized stream, all compared each
// clock against an arithmetic reference model of the audio stage.
`timescale 1ns/1ps
module tb_sdr_audio_dac;

    localparam int MID = 32768;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_en = 1'b1;
    logic        i_wb_cyc = 1'b0;
    logic        i_wb_stb = 1'b0;
    logic        i_wb_we = 1'b0;
    logic [1:0]  i_wb_addr = '0;
    logic [31:0] i_wb_data = '0;
    logic [3:0]  i_wb_sel = 4'hf;
    logic        o_wb_stall;
    logic        o_wb_ack;
    logic [31:0] o_wb_data;
    logic        i_ce = 1'b0;
    logic [31:0] i_sample = '0;
    logic [1:0]  o_pwm;
    logic        o_clip;

    sdr_audio_dac #(
        .NCHAN(2), .IW(16), .GW(16), .PWM_BITS(16), .CLIP_BITS(16)
    ) dut (
        .i_clk(clk), .i_reset(i_reset), .i_en(i_en),
        .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
        .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .i_wb_sel(i_wb_sel),
        .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data),
        .i_ce(i_ce), .i_sample(i_sample), .o_pwm(o_pwm), .o_clip(o_clip)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        int     due;
        longint p0;
        longint p1;
        int     s0;
        int     s1;
        logic   c;
    } item_t;

    item_t       pipe_q[$];
    int          edge_n = 0;
    int          m_gain = 0;
    bit          m_mode = 0;
    bit          m_mute = 0;
    logic [4:0]  m_shift = '0;
    int          m_clipcnt = 0;
    int          m_level[2] = '{MID, MID};
    longint      m_sum[2] = '{0, 0};
    int          m_cnt = 0;
    logic [1:0]  m_pwm = '0;
    bit          m_ack = 0;
    logic [31:0] m_rdata = '0;
    bit          m_clip = 0;

    function automatic int brev16(input int v);
        int r = 0;
        for (int i = 0; i < 16; i++) if (v[i]) r |= (1 << (15 - i));
        return r;
    endfunction

    function automatic void sat_calc(input longint p, input int sh, output int s, output bit c);
        longint v = p >>> sh;
        c = 1'b1;
        if (v > 32767)       s = 32767;
        else if (v < -32768) s = -32768;
        else begin s = int'(v); c = 1'b0; end
    endfunction

    function automatic logic [31:0] reg_read(input logic [1:0] a);
        logic [31:0] r = '0;
        case (a)
            2'd0: r = m_gain;
            2'd1: r = {19'd0, m_shift, 6'd0, m_mute, m_mode};
            2'd2: r = m_clipcnt;
            default: r = m_level[0];
        endcase
        return r;
    endfunction

    // One clock edge of the model, using the inputs the DUT sampled at that edge.
    task automatic model_edge();
        logic [1:0] np;
        bit         nclip;
        item_t      it;
        item_t      keep[$];
        int         s0, s1;
        bit         c0, c1;
        if (i_reset) begin
            pipe_q.delete();
            m_gain = 0; m_mode = 0; m_mute = 0; m_shift = '0; m_clipcnt = 0;
            m_level = '{MID, MID}; m_sum = '{0, 0}; m_cnt = 0;
            m_pwm = '0; m_ack = 0; m_rdata = '0; m_clip = 0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (!i_en) np[c] = ~m_pwm[c];
                else if (m_mode) np[c] = ((m_sum[c] + m_level[c]) / 65536) != (m_sum[c] / 65536);
                else np[c] = brev16(m_cnt) < m_level[c];
                m_sum[c] += m_level[c];
            end
            m_cnt = (m_cnt + 1) % 65536;
            m_pwm = np;
            m_ack = i_wb_stb;
            if (i_wb_stb) m_rdata = reg_read(i_wb_addr);
            nclip = 0;
            foreach (pipe_q[i]) begin
                it = pipe_q[i];
                if (it.due == edge_n) begin
                    m_level[0] = m_mute ? MID : it.s0 + MID;
                    m_level[1] = m_mute ? MID : it.s1 + MID;
                    nclip |= it.c;
                end else begin
                    if (it.due == edge_n + 1) begin
                        sat_calc(it.p0, int'(m_shift), s0, c0);
                        sat_calc(it.p1, int'(m_shift), s1, c1);
                        it.s0 = s0; it.s1 = s1; it.c = c0 | c1;
                    end
                    keep.push_back(it);
                end
            end
            pipe_q = keep;
            if (i_ce) begin
                it = '0;
                it.due = edge_n + 2;
                it.p0 = longint'($signed(i_sample[15:0])) * m_gain;
                it.p1 = longint'($signed(i_sample[31:16])) * m_gain;
                pipe_q.push_back(it);
            end
            m_clip = nclip;
            if (i_wb_stb && i_wb_we && i_wb_addr == 2'd2) m_clipcnt = 0;
            else if (nclip && m_clipcnt < 65535) m_clipcnt++;
            if (i_wb_stb && i_wb_we) begin
                if (i_wb_addr == 2'd0) m_gain = int'($signed(i_wb_data[15:0]));
                if (i_wb_addr == 2'd1) begin
                    m_mode = i_wb_data[0]; m_mute = i_wb_data[1]; m_shift = i_wb_data[12:8];
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        model_edge();
        #1;
        check_eq("pwm",   longint'(o_pwm),     longint'(m_pwm));
        check_eq("clip",  longint'(o_clip),    longint'(m_clip));
        check_eq("ack",   longint'(o_wb_ack),  longint'(m_ack));
        check_eq("rdata", longint'(o_wb_data), longint'(m_rdata));
    endtask

    task automatic wb(input logic [1:0] a, input bit we, input logic [31:0] d,
                      output logic [31:0] rd);
        i_wb_stb = 1'b1; i_wb_we = we; i_wb_addr = a; i_wb_data = d;
        tick();
        rd = o_wb_data;
        i_wb_stb = 1'b0; i_wb_we = 1'b0;
    endtask

    logic [31:0] rd;
    logic [1:0]  prev;
    logic [1:0]  inv;
    logic [15:0] ramp0, ramp1;
    int          ones0, ones1, pulses;

    initial begin
        // 1: reset state and register reads
        @(posedge clk);
        tick();
        tick();
        check_eq("rst_pwm", longint'(o_pwm), 0);
        i_reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            wb(2'(a), 1'b0, '0, rd);
            check_eq("rst_ack", longint'(o_wb_ack), 1);
            check_eq("rst_rd", longint'(rd), (a == 3) ? 32'h8000 : 0);
        end

        // 2: gain/shift path and 3-clock latency
        wb(2'd0, 1'b1, 32'h0100, rd);
        wb(2'd1, 1'b1, 32'h0800, rd);
        i_ce = 1'b1; i_sample = {16'hF000, 16'h1000};
        tick();
        i_ce = 1'b0;
        wb(2'd3, 1'b0, '0, rd); check_eq("lat_e1", longint'(rd), 32'h8000);
        wb(2'd3, 1'b0, '0, rd); check_eq("lat_e2", longint'(rd), 32'h8000);
        wb(2'd3, 1'b0, '0, rd); check_eq("level0", longint'(rd), 32'h9000);
        wb(2'd2, 1'b0, '0, rd); check_eq("noclip", longint'(rd), 0);

        // 3: sigma-delta then PWM density with levels 0x9000 / 0x7000
        wb(2'd1, 1'b1, 32'h0801, rd);
        ones0 = 0; ones1 = 0;
        for (int i = 0; i < 4096; i++) begin
            tick(); ones0 += o_pwm[0]; ones1 += o_pwm[1];
        end
        check_eq("sd_ones0", ones0, 2304);
        check_eq("sd_ones1", ones1, 1792);
        wb(2'd1, 1'b1, 32'h0800, rd);
        while (m_cnt % 4096 != 0) tick();
        ones0 = 0; ones1 = 0;
        for (int i = 0; i < 4096; i++) begin
            tick(); ones0 += o_pwm[0]; ones1 += o_pwm[1];
        end
        check_eq("pwm_ones0", ones0, 2304);
        check_eq("pwm_ones1", ones1, 1792);

        // 4: saturation both ways, clip count, clear beats increment
        wb(2'd0, 1'b1, 32'h7FFF, rd);
        wb(2'd1, 1'b1, 32'h0, rd);
        wb(2'd2, 1'b1, 32'h0, rd);
        pulses = 0;
        i_ce = 1'b1; i_sample = {16'h0000, 16'h7FFF};
        tick(); pulses += o_clip;
        i_sample = {16'h0000, 16'h8000};
        tick(); pulses += o_clip;
        i_ce = 1'b0;
        for (int i = 0; i < 3; i++) begin tick(); pulses += o_clip; end
        check_eq("clip_pulses", pulses, 2);
        wb(2'd2, 1'b0, '0, rd); check_eq("clip_cnt", longint'(rd), 2);
        wb(2'd3, 1'b0, '0, rd); check_eq("sat_low", longint'(rd), 0);
        i_ce = 1'b1; i_sample = {16'h0000, 16'h7FFF};
        tick();
        i_ce = 1'b0;
        tick();
        wb(2'd2, 1'b1, '0, rd);
        check_eq("clr_pulse", longint'(o_clip), 1);
        wb(2'd2, 1'b0, '0, rd); check_eq("clr_wins", longint'(rd), 0);

        // 5: mute, then idle toggle pattern
        wb(2'd1, 1'b1, 32'h2, rd);
        i_ce = 1'b1; i_sample = {16'h4321, 16'h1234};
        tick();
        i_ce = 1'b0;
        repeat (3) tick();
        wb(2'd3, 1'b0, '0, rd); check_eq("mute_level", longint'(rd), 32'h8000);
        wb(2'd1, 1'b1, 32'h0, rd);
        i_en = 1'b0;
        prev = o_pwm;
        for (int i = 0; i < 8; i++) begin
            tick();
            inv = ~prev;
            check_eq("en_toggle", longint'(o_pwm), longint'(inv));
            prev = o_pwm;
        end
        i_en = 1'b1;

        // 6: randomized streaming with a mid-stream reset
        wb(2'd0, 1'b1, 32'h00C3, rd);
        wb(2'd1, 1'b1, 32'h0100, rd);
        ramp0 = 16'h0; ramp1 = 16'h8000;
        for (int i = 0; i < 3000; i++) begin
            i_ce = ($urandom_range(0, 3) != 0);
            ramp0 += 16'h0123;
            ramp1 -= 16'h0457;
            i_sample = {ramp1 ^ 16'($urandom_range(0, 15)), ramp0};
            i_wb_stb = ($urandom_range(0, 1) == 1);
            i_wb_we = i_wb_stb && ($urandom_range(0, 7) == 0);
            i_wb_addr = 2'($urandom_range(0, 3));
            i_wb_data = $urandom;
            if (i_wb_addr == 2'd1) i_wb_data[12:8] = 5'($urandom_range(0, 4));
            i_en = ($urandom_range(0, 15) != 0);
            i_reset = (i == 1500 || i == 1501);
            tick();
        end
        i_reset = 1'b0; i_ce = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0; i_en = 1'b1;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
